// File: rtl/edxel_axi_lite_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the EdXel datapath.
// Single-beat writes with byte-strobe merge, single-beat reads, all responses OKAY.
module edxel_axi_lite_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_out,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_out,
    output logic [3:0]                        reg_wr_pulse
);

    localparam int NB = C_S_AXI_DATA_WIDTH / 8;

    // W_ACK / R_ACK are the one-cycle READY states, so READY comes straight from a flop.
    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

    wstate_t r_wstate, w_wstate_next;
    rstate_t r_rstate, w_rstate_next;

    logic                          w_wr_en;
    logic                          w_rd_en;
    logic [1:0]                    w_wr_sel;
    logic [1:0]                    w_rd_sel;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_regs [4];
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [3:0]                    r_wr_pulse;
    logic                          w_unused;

    // Write FSM
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_wstate <= W_IDLE;
        else        r_wstate <= w_wstate_next;
    end

    always_comb begin
        w_wstate_next = r_wstate;
        case (r_wstate)
            W_IDLE:  if (S_AXI_AWVALID && S_AXI_WVALID) w_wstate_next = W_ACK;
            W_ACK:   w_wstate_next = (S_AXI_AWVALID && S_AXI_WVALID) ? W_RESP : W_IDLE;
            W_RESP:  if (S_AXI_BREADY) w_wstate_next = W_IDLE;
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_AWREADY = (r_wstate == W_ACK);
        S_AXI_WREADY  = (r_wstate == W_ACK);
        S_AXI_BVALID  = (r_wstate == W_RESP);
    end

    // Read FSM
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_rstate <= R_IDLE;
        else        r_rstate <= w_rstate_next;
    end

    always_comb begin
        w_rstate_next = r_rstate;
        case (r_rstate)
            R_IDLE:  if (S_AXI_ARVALID) w_rstate_next = R_ACK;
            R_ACK:   w_rstate_next = S_AXI_ARVALID ? R_DATA : R_IDLE;
            R_DATA:  if (S_AXI_RREADY) w_rstate_next = R_IDLE;
            default: w_rstate_next = R_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = (r_rstate == R_ACK);
        S_AXI_RVALID  = (r_rstate == R_DATA);
    end

    assign w_wr_en  = (r_wstate == W_ACK) && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_en  = (r_rstate == R_ACK) && S_AXI_ARVALID;
    assign w_wr_sel = S_AXI_AWADDR[3:2];
    assign w_rd_sel = S_AXI_ARADDR[3:2];

    genvar gi, gb;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_reg
            logic [C_S_AXI_DATA_WIDTH-1:0] r_reg;
            logic [C_S_AXI_DATA_WIDTH-1:0] w_merged;

            for (gb = 0; gb < NB; gb++) begin : g_byte
                assign w_merged[8*gb +: 8] = S_AXI_WSTRB[gb] ? S_AXI_WDATA[8*gb +: 8]
                                                             : r_reg[8*gb +: 8];
            end

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET)                             r_reg <= '0;
                else if (w_wr_en && w_wr_sel == 2'(gi)) r_reg <= w_merged;
            end

            assign w_regs[gi] = r_reg;
        end
    endgenerate

    // Nonblocking capture means a read sharing the accept edge with a write sees the old value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            if (w_rd_en) r_rdata <= w_regs[w_rd_sel];
            r_wr_pulse <= w_wr_en ? (4'b0001 << w_wr_sel) : 4'b0000;
        end
    end

    assign S_AXI_RDATA  = r_rdata;
    assign S_AXI_BRESP  = 2'b00;
    assign S_AXI_RRESP  = 2'b00;
    assign reg_wr_pulse = r_wr_pulse;
    assign reg0_out     = w_regs[0];
    assign reg1_out     = w_regs[1];
    assign reg2_out     = w_regs[2];
    assign reg3_out     = w_regs[3];

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_edxel_axi_lite_regs.sv
// Directed self-checking bench for edxel_axi_lite_regs; one line per transaction.
module tb_edxel_axi_lite_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [3:0]  wr_pulse;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    edxel_axi_lite_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg0_out(reg0), .reg1_out(reg1), .reg2_out(reg2), .reg3_out(reg3),
        .reg_wr_pulse(wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int idx);
        case (idx)
            0: return reg0;
            1: return reg1;
            2: return reg2;
            default: return reg3;
        endcase
    endfunction

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] exp_pulse);
        int t;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        t = 0;
        while (!(awready && wready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("wr_ready_latency", t, 1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_pulse", wr_pulse, exp_pulse);
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, 2'b00);
        @(negedge clk);
        check("wr_bvalid_drop", bvalid, 1'b0);
        check("wr_pulse_clear", wr_pulse, 4'b0000);
        bready = 1'b0;
        $display("write addr=0x%h data=0x%08h strb=%b pulse=%b", addr, data, strb, exp_pulse);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int t;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rd_ready_latency", t, 1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_data", rdata, exp);
        check("rd_rresp", rresp, 2'b00);
        @(negedge clk);
        check("rd_rvalid_drop", rvalid, 1'b0);
        rready = 1'b0;
        $display("read  addr=0x%h data=0x%08h expected=0x%08h", addr, rdata, exp);
    endtask

    // Present one channel 5 cycles ahead of the other and count the handshakes.
    task automatic ordered_write(input bit w_first, input logic [3:0] addr,
                                 input logic [31:0] data, input int idx);
        int n_rdy, n_split, n_b, n_early;
        bit acc;
        n_rdy = 0; n_split = 0; n_b = 0; n_early = 0; acc = 0;
        @(negedge clk);
        awaddr = addr; wdata = data; wstrb = 4'hF; bready = 1'b1;
        if (w_first) wvalid = 1'b1; else awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (awready || wready) n_early++;
        end
        if (w_first) awvalid = 1'b1; else wvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (acc) begin awvalid = 1'b0; wvalid = 1'b0; acc = 0; end
            if (awready && wready) begin n_rdy++; acc = 1; end
            if (awready != wready) n_split++;
            if (bvalid) n_b++;
        end
        bready = 1'b0;
        check("ord_early_ready", n_early, 0);
        check("ord_ready_pulses", n_rdy, 1);
        check("ord_split_ready", n_split, 0);
        check("ord_bvalid_count", n_b, 1);
        check("ord_reg_value", reg_of(idx), data);
        $display("ordered write w_first=%0d addr=0x%h data=0x%08h reg%0d=0x%08h",
                 w_first, addr, data, idx, reg_of(idx));
    endtask

    initial begin
        int t, n_acc, n_drop, n_unstable;

        // Reset
        #500;
        check("rst_awready", awready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wready", wready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bresp_rresp", {bresp, rresp}, 4'b0000);
        check("rst_pulse", wr_pulse, 4'b0000);
        check("rst_regs_or", reg0 | reg1 | reg2 | reg3, 32'h0);
        $display("reset released");

        // Sequential write / read-back
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 4'b0001);
        axi_read (4'h0, 32'h0101FFFF);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 4'b0010);
        axi_read (4'h4, 32'hABCD0001);
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 4'b0100);
        axi_read (4'h8, 32'hDEAD0011);
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 4'b1000);
        axi_read (4'hC, 32'hBEEF0011);

        // Byte strobes, including an all-zero strobe that must still pulse
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF, 4'b0010);
        axi_write(4'h4, 32'h12345678, 4'b0101, 4'b0010);
        axi_read (4'h4, 32'hFF34FF78);
        axi_write(4'h4, 32'h00000000, 4'b0000, 4'b0010);
        axi_read (4'h4, 32'hFF34FF78);

        // Channel ordering, with aliased addresses
        ordered_write(1'b1, 4'h1, 32'hCAFE0001, 0);
        ordered_write(1'b0, 4'hF, 32'h5A5A0000, 3);

        // Write backpressure with a second write pending
        @(negedge clk);
        awaddr = 4'h4; wdata = 32'h11112222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        check("bp_first_accept", t < 20, 1'b1);
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h33334444;
        check("bp_reg1_first", reg1, 32'h11112222);
        n_acc = 0; n_drop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bvalid) n_drop++;
            if (awready || wready) n_acc++;
        end
        check("bp_bvalid_held", n_drop, 0);
        check("bp_no_second_accept", n_acc, 0);
        check("bp_reg0_unchanged", reg0, 32'hCAFE0001);
        bready = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        check("bp_second_accept", t < 20, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_reg0_second", reg0, 32'h33334444);
        check("bp_pulse_second", wr_pulse, 4'b0001);
        @(negedge clk);
        check("bp_bvalid_done", bvalid, 1'b0);
        bready = 1'b0;
        $display("write backpressure: reg1=0x%08h reg0=0x%08h", reg1, reg0);

        // Read backpressure: RDATA must not move while a write changes the register
        @(negedge clk);
        araddr = 4'h4; arvalid = 1'b1; rready = 1'b0;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk); t++; end
        check("rbp_accept", t < 20, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rbp_rdata", rdata, 32'h11112222);
        axi_write(4'h4, 32'h99990000, 4'hF, 4'b0010);
        n_unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!rvalid || rdata !== 32'h11112222) n_unstable++;
        end
        check("rbp_rdata_stable", n_unstable, 0);
        rready = 1'b1;
        @(negedge clk);
        check("rbp_rvalid_done", rvalid, 1'b0);
        rready = 1'b0;
        $display("read backpressure: rdata held 0x11112222");

        // Same-edge read and write to 0x8
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'h0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h8; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("same_edge_ready", {awready, arready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_edge_rdata_old", rdata, 32'hDEAD0011);
        check("same_edge_reg2_new", reg2, 32'h0);
        check("same_edge_both_valid", {bvalid, rvalid}, 2'b11);
        @(negedge clk);
        check("same_edge_both_done", {bvalid, rvalid}, 2'b00);
        bready = 1'b0; rready = 1'b0;
        $display("same-edge rd/wr addr=0x8 rdata=0xDEAD0011 reg2=0x%08h", reg2);
        axi_read(4'h8, 32'h00000000);

        // Reset while a B response is pending
        @(negedge clk);
        awaddr = 4'h8; wdata = 32'h77777777; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk); t++; end
        check("mid_rst_accept", t < 20, 1'b1);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("mid_rst_bvalid_before", bvalid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_bvalid_drop", bvalid, 1'b0);
        check("mid_rst_reg2", reg2, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        $display("reset asserted with BVALID pending");
        axi_read(4'h0, 32'h0);
        axi_read(4'h4, 32'h0);
        axi_read(4'h8, 32'h0);
        axi_read(4'hC, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
